// File: rtl/my9262_rx.sv
// my9262_rx: deserialises the my9262 grayscale stream, commits frames on Lat, regenerates PWM from Gck.
module my9262_rx #(
    parameter int CHANNELS    = 16,
    parameter int GS_WIDTH    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                        CLK_200M,
    input  logic                                        RST,
    input  logic                                        my9262_Lat,
    input  logic                                        my9262_Dclk,
    input  logic                                        my9262_Gck,
    input  logic                                        my9262_Di,
    output logic [CHANNELS*GS_WIDTH-1:0]                gs_flat,
    output logic [CHANNELS-1:0]                         pwm_out,
    output logic                                        frame_valid,
    output logic                                        frame_err,
    output logic [$clog2(CHANNELS*GS_WIDTH+2)-1:0]      bit_cnt,
    output logic [GS_WIDTH-1:0]                         gck_cnt
);
    localparam int N  = CHANNELS * GS_WIDTH;
    localparam int BW = $clog2(N + 2);

    logic [SYNC_STAGES:0]   lat_sync_q, dclk_sync_q, gck_sync_q;
    logic [SYNC_STAGES-1:0] di_sync_q;
    logic                   lat_rise, dclk_rise, gck_rise, di;
    logic [N-1:0]           shift_q, shift_d, gs_q, gs_d;
    logic [BW-1:0]          cnt_q, cnt_d, cnt_post;
    logic [GS_WIDTH-1:0]    phase_q, phase_d;
    logic [CHANNELS-1:0]    pwm_q, pwm_d;
    logic                   valid_q, valid_d, err_q, err_d, full, good;

    // Synchronise the asynchronous pins; the top bit of each control chain is the history flop
    always_ff @(posedge CLK_200M or posedge RST) begin
        if (RST) begin
            lat_sync_q  <= '0;
            dclk_sync_q <= '0;
            gck_sync_q  <= '0;
            di_sync_q   <= '0;
        end else begin
            lat_sync_q  <= {lat_sync_q[SYNC_STAGES-1:0], my9262_Lat};
            dclk_sync_q <= {dclk_sync_q[SYNC_STAGES-1:0], my9262_Dclk};
            gck_sync_q  <= {gck_sync_q[SYNC_STAGES-1:0], my9262_Gck};
            di_sync_q   <= {di_sync_q[SYNC_STAGES-2:0], my9262_Di};
        end
    end

    assign lat_rise  = lat_sync_q[SYNC_STAGES-1]  & ~lat_sync_q[SYNC_STAGES];
    assign dclk_rise = dclk_sync_q[SYNC_STAGES-1] & ~dclk_sync_q[SYNC_STAGES];
    assign gck_rise  = gck_sync_q[SYNC_STAGES-1]  & ~gck_sync_q[SYNC_STAGES];
    assign di        = di_sync_q[SYNC_STAGES-1];

    // Shift first, then let a coincident latch judge the post-shift count and data
    always_comb begin
        shift_d  = dclk_rise ? {shift_q[N-2:0], di} : shift_q;
        cnt_post = (dclk_rise && cnt_q != BW'(N + 1)) ? cnt_q + 1'b1 : cnt_q;
        full     = cnt_post == BW'(N);
        good     = lat_rise && full;
        cnt_d    = lat_rise ? '0 : cnt_post;
        gs_d     = good ? shift_d : gs_q;
        valid_d  = good;
        err_d    = lat_rise && !full;
        phase_d  = good ? '0 : gck_rise ? phase_q + 1'b1 : phase_q;
    end

    // PWM compare per channel against the current phase
    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++)
            pwm_d[i] = phase_q < gs_q[i*GS_WIDTH +: GS_WIDTH];
    end

    // Frame, phase and PWM state
    always_ff @(posedge CLK_200M or posedge RST) begin
        if (RST) begin
            shift_q <= '0;
            cnt_q   <= '0;
            gs_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            phase_q <= '0;
            pwm_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            gs_q    <= gs_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            phase_q <= phase_d;
            pwm_q   <= pwm_d;
        end
    end

    assign gs_flat     = gs_q;
    assign pwm_out     = pwm_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign bit_cnt     = cnt_q;
    assign gck_cnt     = phase_q;
endmodule

// File: tb/tb_my9262_rx.sv
// tb_my9262_rx: table-driven and randomized checks of my9262_rx against a frame-level model.
`timescale 1ns/1ps
module tb_my9262_rx;
    localparam int N = 256;

    typedef struct {
        int          pulses;
        logic [3:0]  pwm;
        logic [15:0] phase;
    } pwm_vec_t;

    logic           clk = 1'b0, rst = 1'b1;
    logic           lat = 1'b0, dclk = 1'b0, gck = 1'b0, di = 1'b0;
    logic [N-1:0]   gs_flat;
    logic [15:0]    pwm_out;
    logic           frame_valid, frame_err;
    logic [8:0]     bit_cnt;
    logic [15:0]    gck_cnt;

    int vectors = 0, miscompares = 0, nv = 0, ne = 0;

    bit          mq[$];
    logic [15:0] mg[16];
    int          mphase;

    my9262_rx dut (
        .CLK_200M(clk), .RST(rst), .my9262_Lat(lat), .my9262_Dclk(dclk),
        .my9262_Gck(gck), .my9262_Di(di), .gs_flat(gs_flat), .pwm_out(pwm_out),
        .frame_valid(frame_valid), .frame_err(frame_err), .bit_cnt(bit_cnt), .gck_cnt(gck_cnt)
    );

    always #2.5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) nv++;
        if (frame_err) ne++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] mflat();
        logic [N-1:0] r;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = mg[i];
        return r;
    endfunction

    function automatic logic [15:0] mpwm();
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = mphase < int'(mg[i]);
        return r;
    endfunction

    function automatic logic [N-1:0] rand_frame();
        logic [N-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 16; i++) mg[i] = '0;
        mphase = 0;
    endtask

    task automatic check_state(input string tag);
        int c;
        c = mq.size() > N + 1 ? N + 1 : mq.size();
        check({tag, "_gs"}, gs_flat, mflat());
        check({tag, "_bitcnt"}, N'(bit_cnt), N'(c));
        check({tag, "_gckcnt"}, N'(gck_cnt), N'(mphase));
        check({tag, "_pwm"}, N'(pwm_out), N'(mpwm()));
    endtask

    task automatic send_bit(input bit b);
        di = b;
        dclk = 1'b1;
        tick(3);
        dclk = 1'b0;
        tick(3);
        mq.push_back(b);
    endtask

    task automatic send_bits(input logic [N-1:0] f, input int nb);
        for (int k = 0; k < nb; k++) send_bit(k < N ? f[N-1-k] : 1'($urandom));
    endtask

    task automatic gck_pulse();
        gck = 1'b1;
        tick(3);
        gck = 1'b0;
        tick(5);
        mphase = (mphase + 1) % 65536;
        check_state("gck");
    endtask

    task automatic do_lat(input bit wb, input bit b, input bit wg);
        int v0, e0;
        bit ok;
        logic [N-1:0] f;
        v0 = nv;
        e0 = ne;
        if (wb) begin
            di = b;
            dclk = 1'b1;
            mq.push_back(b);
        end
        if (wg) gck = 1'b1;
        lat = 1'b1;
        tick(3);
        lat = 1'b0;
        dclk = 1'b0;
        gck = 1'b0;
        tick(5);
        ok = mq.size() == N;
        if (ok) begin
            for (int k = 0; k < N; k++) f[N-1-k] = mq[k];
            for (int i = 0; i < 16; i++) mg[i] = f[i*16 +: 16];
            mphase = 0;
        end else if (wg) mphase = (mphase + 1) % 65536;
        mq.delete();
        check("valid_pulses", N'(nv - v0), N'(ok));
        check("err_pulses", N'(ne - e0), N'(!ok));
        check_state("lat");
    endtask

    pwm_vec_t pv[4];
    logic [N-1:0] f;
    int len, wb;

    initial begin
        pv[0] = '{0, 4'b1110, 16'd0};
        pv[1] = '{1, 4'b1100, 16'd1};
        pv[2] = '{1, 4'b1100, 16'd2};
        pv[3] = '{1, 4'b0100, 16'd3};
        model_reset();
        for (int c = 0; c < 12; c++) begin
            {lat, dclk, gck, di} = 4'($urandom);
            tick(1);
            if (c % 4 == 3) begin
                check("rst_gs", gs_flat, '0);
                check("rst_pwm", N'(pwm_out), '0);
                check("rst_valid", N'(frame_valid), '0);
                check("rst_err", N'(frame_err), '0);
                check("rst_bitcnt", N'(bit_cnt), '0);
                check("rst_gckcnt", N'(gck_cnt), '0);
            end
        end
        {lat, dclk, gck, di} = 4'b0;
        tick(4);
        rst = 1'b0;
        tick(4);
        check_state("post_rst");
        for (int i = 0; i < 16; i++) f[i*16 +: 16] = 16'(16'h1000 * i + i);
        send_bits(f, N);
        check("good_pre_bitcnt", N'(bit_cnt), N'(N));
        do_lat(0, 0, 0);
        check("good_ch5", N'(gs_flat[5*16 +: 16]), N'(16'h5005));
        send_bits('1, N - 1);
        do_lat(0, 0, 0);
        check("short_gs_kept", gs_flat, f);
        send_bits(rand_frame(), N + 1);
        check("long_bitcnt", N'(bit_cnt), N'(N + 1));
        send_bit(1'b1);
        check("sat_bitcnt", N'(bit_cnt), N'(N + 1));
        do_lat(0, 0, 0);
        f = rand_frame();
        send_bits(f, N - 1);
        do_lat(1, f[0], 0);
        check("coinc_gs", gs_flat, f);
        f = rand_frame();
        f[63:0] = {16'd3, 16'hFFFF, 16'd1, 16'd0};
        send_bits(f, N);
        do_lat(0, 0, 0);
        for (int v = 0; v < 4; v++) begin
            repeat (pv[v].pulses) gck_pulse();
            check("pwm_tbl", N'(pwm_out[3:0]), N'(pv[v].pwm));
            check("phase_tbl", N'(gck_cnt), N'(pv[v].phase));
        end
        send_bits(f, N);
        do_lat(0, 0, 1);
        check("gck_clear", N'(gck_cnt), '0);
        send_bits(rand_frame(), 100);
        rst = 1'b1;
        #1;
        check("midrst_bitcnt", N'(bit_cnt), '0);
        check("midrst_gs", gs_flat, '0);
        tick(3);
        rst = 1'b0;
        model_reset();
        tick(3);
        f = rand_frame();
        send_bits(f, N);
        do_lat(0, 0, 0);
        check("midrst_new_gs", gs_flat, f);
        for (int it = 0; it < 6; it++) begin
            case ($urandom_range(0, 4))
                0, 1: len = N;
                2: len = N - 1;
                3: len = N + 1;
                default: len = $urandom_range(0, 6);
            endcase
            f = rand_frame();
            wb = (len > 0) ? int'($urandom_range(0, 1)) : 0;
            send_bits(f, len - wb);
            do_lat(wb != 0, (len - 1 < N && len > 0) ? f[N-len] : 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) gck_pulse();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
